// File: rtl/fetch_seq_pkg.sv
// Shared types and phase indices for the fetch trigger sequencer.
package fetch_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2,
        HOLD = 2'd3
    } seq_state_t;

    // Default roles of the first five phases; extra phases are appended after PH_OUT_LATCH.
    localparam int PH_LATCH     = 0;
    localparam int PH_UPDATE_PC = 1;
    localparam int PH_FETCH     = 2;
    localparam int PH_DECODE    = 3;
    localparam int PH_OUT_LATCH = 4;

endpackage

// File: rtl/seq_edge_detect.sv
// Rising-edge detector: rise is high while din is high and was low on the previous edge.
module seq_edge_detect (
    input  logic clock,
    input  logic reset_n,
    input  logic din,
    output logic rise
);

    logic din_reg;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            din_reg <= 1'b0;
        end else begin
            din_reg <= din;
        end
    end

    assign rise = din & ~din_reg;

endmodule

// File: rtl/phase_sequencer.sv
// One-hot phase trigger generator with start/stop, hold, single-step,
// programmable inter-phase gap and a completed-cycle counter.
module phase_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int NUM_PHASES = 5,
    parameter int GAP_W      = 4,
    parameter int CNT_W      = 16,
    localparam int PH_W      = $clog2(NUM_PHASES)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  hold,
    input  logic                  step_mode,
    input  logic                  step,
    input  logic [GAP_W-1:0]      gap,
    output logic [NUM_PHASES-1:0] trigger,
    output logic [PH_W-1:0]       phase,
    output logic                  busy,
    output logic                  cycle_done,
    output logic [CNT_W-1:0]      cycle_count
);

    localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(NUM_PHASES - 1);

    seq_state_t            state_reg;
    logic [NUM_PHASES-1:0] trigger_reg;
    logic [PH_W-1:0]       phase_reg;
    logic                  busy_reg;
    logic                  cycle_done_reg;
    logic [CNT_W-1:0]      cycle_count_reg;
    logic [GAP_W-1:0]      gap_lat_reg;
    logic [GAP_W-1:0]      gap_cnt_reg;

    logic                  step_rise;
    logic                  step_ok;
    logic                  seq_end;
    logic                  do_start;
    logic                  do_advance;
    logic                  do_gap;
    logic                  do_hold;
    logic                  do_idle;
    logic [PH_W-1:0]       next_phase;
    logic [NUM_PHASES-1:0] next_onehot;

    seq_edge_detect u_step_edge (
        .clock   (clock),
        .reset_n (reset_n),
        .din     (step),
        .rise    (step_rise)
    );

    assign step_ok    = !step_mode || step_rise;
    assign next_phase = phase_reg + 1'b1;

    generate
        for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_onehot
            assign next_onehot[gi] = (next_phase == PH_W'(gi));
        end
    endgenerate

    // seq_end marks the edge where the current phase (and its gap) is finished.
    always_comb begin
        seq_end    = ((state_reg == RUN) && (gap_lat_reg == '0)) ||
                     ((state_reg == GAP) && (gap_cnt_reg == '0));
        do_start   = 1'b0;
        do_advance = 1'b0;
        do_gap     = 1'b0;
        do_hold    = 1'b0;
        do_idle    = 1'b0;
        case (state_reg)
            IDLE:    do_start = enable && step_ok;
            RUN:     do_gap   = (gap_lat_reg != '0);
            HOLD: begin
                if (!enable) do_idle  = 1'b1;
                else         do_start = !hold && step_ok;
            end
            default: ;
        endcase
        if (seq_end) begin
            if (phase_reg != LAST_PHASE)  do_advance = 1'b1;
            else if (!enable)             do_idle    = 1'b1;
            else if (hold || step_mode)   do_hold    = 1'b1;
            else                          do_start   = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            trigger_reg     <= '0;
            phase_reg       <= '0;
            busy_reg        <= 1'b0;
            cycle_done_reg  <= 1'b0;
            cycle_count_reg <= '0;
            gap_lat_reg     <= '0;
            gap_cnt_reg     <= '0;
        end else begin
            trigger_reg    <= '0;
            cycle_done_reg <= 1'b0;
            if (do_start) begin
                state_reg   <= RUN;
                trigger_reg <= NUM_PHASES'(1);
                phase_reg   <= PH_W'(PH_LATCH);
                gap_lat_reg <= gap;
                busy_reg    <= 1'b1;
            end else if (do_advance) begin
                state_reg   <= RUN;
                trigger_reg <= next_onehot;
                phase_reg   <= next_phase;
                busy_reg    <= 1'b1;
                if (next_phase == LAST_PHASE) begin
                    cycle_done_reg  <= 1'b1;
                    cycle_count_reg <= cycle_count_reg + 1'b1;
                end
            end else if (do_gap) begin
                state_reg   <= GAP;
                gap_cnt_reg <= gap_lat_reg - 1'b1;
            end else if (do_hold) begin
                state_reg <= HOLD;
                busy_reg  <= 1'b0;
            end else if (do_idle) begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
            end else if (state_reg == GAP) begin
                gap_cnt_reg <= gap_cnt_reg - 1'b1;
            end
        end
    end

    assign trigger     = trigger_reg;
    assign phase       = phase_reg;
    assign busy        = busy_reg;
    assign cycle_done  = cycle_done_reg;
    assign cycle_count = cycle_count_reg;

endmodule
